// File: rtl/psx_input_state_arbiter.sv
`default_nettype none
// ============================================================================
// psx_input_state_arbiter : atomic-burst arbiter for the Dual Shock input_state write port
// Rev 1.0
// ============================================================================
module psx_input_state_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic       a_req,
  input  logic [4:0] a_addr,
  input  logic [7:0] a_data,
  input  logic       a_last,
  output logic       a_gnt,
  input  logic       b_req,
  input  logic [4:0] b_addr,
  input  logic [7:0] b_data,
  input  logic       b_last,
  output logic       b_gnt,
  output logic [4:0] write_addr,
  output logic [7:0] write_data,
  output logic       write_en,
  output logic       burst_abort
);

  localparam int            CW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BURST_A = 2'd1,
    S_BURST_B = 2'd2
  } state_t;

  state_t        state;
  logic          last_winner_b;
  logic [CW-1:0] idle_cnt;
  logic          a_xfer;
  logic          b_xfer;

  // New bursts only start from idle with no PSX packet running; a locked owner ignores hold.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      case (state)
        S_IDLE: begin
          if (!hold) begin
            if (a_req && (!b_req || last_winner_b)) a_gnt = 1'b1;
            else if (b_req)                         b_gnt = 1'b1;
          end
        end
        S_BURST_A: a_gnt = 1'b1;
        S_BURST_B: b_gnt = 1'b1;
        default: ;
      endcase
    end
  end

  assign a_xfer = a_req & a_gnt;
  assign b_xfer = b_req & b_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      last_winner_b <= 1'b1;
      idle_cnt      <= '0;
      write_en      <= 1'b0;
      write_addr    <= '0;
      write_data    <= '0;
      burst_abort   <= 1'b0;
    end else begin
      write_en    <= 1'b0;
      burst_abort <= 1'b0;
      if (a_xfer) begin
        write_en      <= 1'b1;
        write_addr    <= a_addr;
        write_data    <= a_data;
        last_winner_b <= 1'b0;
        idle_cnt      <= '0;
        state         <= a_last ? S_IDLE : S_BURST_A;
      end else if (b_xfer) begin
        write_en      <= 1'b1;
        write_addr    <= b_addr;
        write_data    <= b_data;
        last_winner_b <= 1'b1;
        idle_cnt      <= '0;
        state         <= b_last ? S_IDLE : S_BURST_B;
      end else if (state != S_IDLE) begin
        // Owner is locked but silent; beats already written stay written.
        if (idle_cnt == C_TO_LAST) begin
          state       <= S_IDLE;
          idle_cnt    <= '0;
          burst_abort <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + CW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire
